// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the normalizer datapath.
//   DEF_MANT_W : default mantissa width, hidden bit included (MSB)
//   DEF_EXP_W  : default biased exponent width
//   DEF_SH_W   : default shift-amount width (2**DEF_SH_W > DEF_MANT_W)
//   norm_state_t : normalizer FSM states
package fpu_pkg;

  localparam int DEF_MANT_W = 24;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_SH_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

endpackage

// File: rtl/fract_normalizer_if.sv
// Valid/ready operand and result bus of the fraction normalizer.
//   in_valid/in_ready   : operand handshake (in_mant, in_exp)
//   out_valid/out_ready : result handshake (out_mant, out_exp, out_shamt, out_zero)
// master = producer/consumer side (add/sub stage + rounding stage), slave = normalizer.
interface fract_normalizer_if #(
  parameter int MANT_W = fpu_pkg::DEF_MANT_W,
  parameter int EXP_W  = fpu_pkg::DEF_EXP_W,
  parameter int SH_W   = fpu_pkg::DEF_SH_W
);

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic [SH_W-1:0]   out_shamt;
  logic              out_zero;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero
  );

endinterface

// File: rtl/lzc4.sv
// Combinational 4-bit leading-zero counter.
//   nib   : input nibble, bit 3 is the most significant
//   count : number of leading zeros, 0..4 (4 means nibble is zero)
module lzc4 (
  input  logic [3:0] nib,
  output logic [2:0] count
);

  always_comb begin
    casez (nib)
      4'b1???: count = 3'd0;
      4'b01??: count = 3'd1;
      4'b001?: count = 3'd2;
      4'b0001: count = 3'd3;
      default: count = 3'd4;
    endcase
  end

endmodule

// File: rtl/fract_normalizer.sv
// Iterative left-normalizer: shifts the mantissa left by up to 4 bits per
// cycle until the hidden bit is set or the exponent would drop below 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fract_normalizer_if (operand in, result out)
// The mant/exp/shamt/zero registers are the result registers; they are only
// meaningful while out_valid is high.
module fract_normalizer
  import fpu_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int SH_W   = DEF_SH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  fract_normalizer_if.slave  bus
);

  norm_state_t       state_q, state_d;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic [SH_W-1:0]   shamt_q;
  logic              zero_q;

  logic [2:0]       lz;
  logic [EXP_W-1:0] lim;
  logic             floor_hit;
  logic [2:0]       step;
  logic             accept;

  lzc4 u_lzc4 (
    .nib   (mant_q[MANT_W-1 -: 4]),
    .count (lz)
  );

  // lim is the largest shift that keeps the exponent >= 1. In SHIFT the
  // exponent is always >= 1, so lim never underflows.
  assign lim       = exp_q - EXP_W'(1);
  assign floor_hit = lim < EXP_W'(lz);
  assign step      = floor_hit ? lim[2:0] : lz;
  assign accept    = (state_q == IDLE) && bus.in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_mant == '0 || bus.in_exp == '0) state_d = DONE;
          else                                         state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Only a full nibble of zeros without hitting the floor needs another pass.
        if (lz == 3'd4 && !floor_hit) state_d = SHIFT;
        else                          state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_mant  = mant_q;
    bus.out_exp   = exp_q;
    bus.out_shamt = shamt_q;
    bus.out_zero  = zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q  <= '0;
      exp_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      shamt_q <= '0;
      if (bus.in_mant == '0) begin
        mant_q <= '0;
        exp_q  <= '0;
        zero_q <= 1'b1;
      end else begin
        mant_q <= bus.in_mant;
        exp_q  <= bus.in_exp;
        zero_q <= 1'b0;
      end
    end else if (state_q == SHIFT) begin
      mant_q  <= mant_q << step;
      shamt_q <= shamt_q + SH_W'(step);
      // Running out of exponent leaves the value denormal: encode exp as 0.
      exp_q   <= floor_hit ? '0 : exp_q - EXP_W'(step);
    end
  end

endmodule
